demux4_frame_collector: RTL and testbench

- Sequential stage directly downstream of the 1:4 demux.
- Takes a serial stream of WIDTH-bit beats with a valid/ready handshake and steers successive beats into output lanes y0, y1, y2, y3 in round-robin order (slot 0..3).
- Holds each completed 4-beat frame stable until the consumer accepts it.
- Also exports the current slot as a 2-bit select, so a combinational 1:4 demux can be driven in lockstep.

---
 rtl/demux4_frame_collector.sv | 105 ++++++++++
 tb/tb_demux4_frame_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux4_frame_collector.sv
// Collects four successive handshaked beats into lanes y0..y3 and holds the frame until the consumer accepts it.
// Define DEMUX_FLUSH_EN to add a synchronous flush input that drops any partial or held frame.
module demux4_frame_collector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DEMUX_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    input  logic             frame_ready
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       sel_reg;
    logic [1:0]       sel_next;
    logic             in_ready_reg;
    logic             accept;
    logic             flush_int;
    logic [WIDTH-1:0] lane_reg [4];

`ifdef DEMUX_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        accept     = 1'b0;
        case (state_reg)
            FILL: begin
                accept = in_valid & in_ready_reg;
                if (accept) begin
                    sel_next = sel_reg + 2'd1;
                    if (sel_reg == 2'd3) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
        // Flush wins over a simultaneous accept or frame handshake.
        if (flush_int) begin
            state_next = FILL;
            sel_next   = 2'd0;
            accept     = 1'b0;
        end
    end

    // in_ready is registered from the next state so it carries no path from in_valid or frame_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FILL;
            sel_reg      <= 2'd0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            in_ready_reg <= (state_next == FILL);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (accept && (sel_reg == 2'(gi))) begin
                    lane_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    assign in_ready    = in_ready_reg;
    assign sel         = sel_reg;
    assign frame_valid = (state_reg == HOLD);
    assign y0          = lane_reg[0];
    assign y1          = lane_reg[1];
    assign y2          = lane_reg[2];
    assign y3          = lane_reg[3];

endmodule

// File: tb/tb_demux4_frame_collector.sv
// Directed bench for demux4_frame_collector (WIDTH=1); covers the optional flush when DEMUX_FLUSH_EN is defined.
module tb_demux4_frame_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [0:0] in_data = 1'b0;
    logic       in_ready;
    logic [1:0] sel;
    logic [0:0] y0, y1, y2, y3;
    logic       frame_valid;
    logic       frame_ready = 1'b0;
`ifdef DEMUX_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    demux4_frame_collector #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DEMUX_FLUSH_EN
        .flush       (flush),
`endif
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sel         (sel),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input logic [3:0] exp);
        chk({tag, ".y0"}, 32'(y0), 32'(exp[0]));
        chk({tag, ".y1"}, 32'(y1), 32'(exp[1]));
        chk({tag, ".y2"}, 32'(y2), 32'(exp[2]));
        chk({tag, ".y3"}, 32'(y3), 32'(exp[3]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with a beat presented; checks sel afterwards.
    task automatic beat(input string tag, input logic v, input logic d, input logic [1:0] exp_sel);
        in_valid = v;
        in_data  = d;
        tick();
        chk({tag, ".sel"}, 32'(sel), 32'(exp_sel));
    endtask

    task automatic handoff(input string tag);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk({tag, ".fv"}, 32'(frame_valid), 32'd0);
        chk({tag, ".ir"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.fv", 32'(frame_valid), 32'd0);
        chk("rst.ir", 32'(in_ready), 32'd0);
        chk_lanes("rst", 4'b0000);
        rst = 1'b0;
        tick();
        chk("rel.ir", 32'(in_ready), 32'd1);
        chk("rel.sel", 32'(sel), 32'd0);

        // 1: stream 1,0,1,1 then hold
        beat("t1.b0", 1'b1, 1'b1, 2'd1);
        beat("t1.b1", 1'b1, 1'b0, 2'd2);
        beat("t1.b2", 1'b1, 1'b1, 2'd3);
        beat("t1.b3", 1'b1, 1'b1, 2'd0);
        in_valid = 1'b0;
        chk("t1.fv", 32'(frame_valid), 32'd1);
        chk("t1.ir", 32'(in_ready), 32'd0);
        chk_lanes("t1", 4'b1101);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1.hold.fv", 32'(frame_valid), 32'd1);
            chk_lanes("t1.hold", 4'b1101);
        end

        // 2: handoff then 0,1,0,0
        handoff("t2.ho");
        beat("t2.b0", 1'b1, 1'b0, 2'd1);
        chk("t2.b0.fv", 32'(frame_valid), 32'd0);
        chk_lanes("t2.partial", 4'b1100);
        beat("t2.b1", 1'b1, 1'b1, 2'd2);
        beat("t2.b2", 1'b1, 1'b0, 2'd3);
        beat("t2.b3", 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        chk("t2.fv", 32'(frame_valid), 32'd1);
        chk_lanes("t2", 4'b0010);

        // 3: gapped stream, garbage data during gaps
        handoff("t3.ho");
        beat("t3.c0", 1'b1, 1'b1, 2'd1);
        beat("t3.c1", 1'b0, 1'b0, 2'd1);
        beat("t3.c2", 1'b0, 1'b1, 2'd1);
        beat("t3.c3", 1'b1, 1'b0, 2'd2);
        beat("t3.c4", 1'b0, 1'b0, 2'd2);
        beat("t3.c5", 1'b1, 1'b1, 2'd3);
        chk("t3.c5.fv", 32'(frame_valid), 32'd0);
        beat("t3.c6", 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        chk("t3.fv", 32'(frame_valid), 32'd1);
        chk_lanes("t3", 4'b0101);

        // 4: async reset mid-frame
        handoff("t4.ho");
        beat("t4.b0", 1'b1, 1'b1, 2'd1);
        beat("t4.b1", 1'b1, 1'b1, 2'd2);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t4.rst.sel", 32'(sel), 32'd0);
        chk("t4.rst.ir", 32'(in_ready), 32'd0);
        chk("t4.rst.fv", 32'(frame_valid), 32'd0);
        chk_lanes("t4.rst", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t4.rel.ir", 32'(in_ready), 32'd1);
        beat("t4.n0", 1'b1, 1'b1, 2'd1);
        beat("t4.n1", 1'b1, 1'b1, 2'd2);
        beat("t4.n2", 1'b1, 1'b1, 2'd3);
        beat("t4.n3", 1'b1, 1'b1, 2'd0);
        chk("t4.fv", 32'(frame_valid), 32'd1);
        chk_lanes("t4", 4'b1111);

        // 5: in_valid ignored during hold
        in_valid = 1'b1;
        in_data  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5.sel", 32'(sel), 32'd0);
            chk("t5.fv", 32'(frame_valid), 32'd1);
            chk("t5.ir", 32'(in_ready), 32'd0);
            chk_lanes("t5", 4'b1111);
        end
        in_valid = 1'b0;

`ifdef DEMUX_FLUSH_EN
        // 6: flush beats a simultaneous accept of the 4th beat
        handoff("t6.ho");
        beat("t6.b0", 1'b1, 1'b0, 2'd1);
        beat("t6.b1", 1'b1, 1'b0, 2'd2);
        beat("t6.b2", 1'b1, 1'b0, 2'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 1'b0;
        tick();
        flush = 1'b0;
        chk("t6.fl.sel", 32'(sel), 32'd0);
        chk("t6.fl.fv", 32'(frame_valid), 32'd0);
        chk("t6.fl.ir", 32'(in_ready), 32'd1);
        chk_lanes("t6.fl", 4'b1000);
        beat("t6.n0", 1'b1, 1'b1, 2'd1);
        beat("t6.n1", 1'b1, 1'b0, 2'd2);
        beat("t6.n2", 1'b1, 1'b1, 2'd3);
        beat("t6.n3", 1'b1, 1'b0, 2'd0);
        in_valid = 1'b0;
        chk("t6.fv", 32'(frame_valid), 32'd1);
        chk_lanes("t6", 4'b0101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
